trig_event_arbiter: RTL and testbench

- Collects rising-edge events from N asynchronous-use trigger inputs (keys, buttons, strobes) and holds each as a pending request.
- Serialises the pending requests onto one valid/ready event channel using round-robin selection.
- Sits between the raw trigger inputs and the single control FSM that consumes key events, so simultaneous presses are never lost or merged.

---
 rtl/trig_event_arbiter.sv | 141 ++++++++++++++
 tb/tb_trig_event_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/trig_event_arbiter.sv
// Round-robin arbiter that turns rising edges on N trigger inputs into serialised valid/ready events.
// Optional KEY_AUTOREPEAT_EN adds per-input hold counters that inject repeat requests.
module trig_event_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned IDXW    = 2,
   parameter int unsigned RPT_DLY = 50000000,
   parameter int unsigned RPT_PER = 10000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    in_trig,
   input  logic            evt_ready,
   input  logic            ovr_clr,
   output logic            evt_valid,
   output logic [IDXW-1:0] evt_idx,
   output logic [N-1:0]    pend,
   output logic [N-1:0]    ovr
);

   localparam int unsigned SW = IDXW + 1;

   // Reject parameter sets the index arithmetic cannot represent
   if (N < 2 || N > 16 || (1 << IDXW) < N || RPT_PER == 0 || RPT_PER > RPT_DLY) begin : g_bad_cfg
      $error("trig_event_arbiter: illegal parameter combination");
   end

   typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

   state_t          state;
   logic [N-1:0]    trig_d;
   logic [IDXW-1:0] ptr;
   logic [N-1:0]    rise;
   logic [N-1:0]    rpt;
   logic [N-1:0]    acc_vec;
   logic [N-1:0]    pend_nxt;
   logic [N-1:0]    ovr_nxt;
   logic            sel_found;
   logic [IDXW-1:0] sel_idx;
   logic [SW-1:0]   scan;

   assign rise = in_trig & ~trig_d;

`ifdef KEY_AUTOREPEAT_EN
   localparam int unsigned CW = $clog2(RPT_DLY + 1);

   logic [CW-1:0] hold_cnt [N];

   // A repeat fires on the edge where the hold count would reach RPT_DLY
   always_comb begin
      rpt = '0;
      for (int unsigned i = 0; i < N; i++) begin
         rpt[i] = in_trig[i] & ~rise[i] & (hold_cnt[i] == CW'(RPT_DLY - 1));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < N; i++) hold_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            if (!in_trig[i] || rise[i])
               hold_cnt[i] <= '0;
            else if (rpt[i])
               hold_cnt[i] <= CW'(RPT_DLY - RPT_PER);
            else
               hold_cnt[i] <= hold_cnt[i] + CW'(1);
         end
      end
   end
`else
   assign rpt = '0;
`endif

   // One-hot of the request being accepted this cycle
   always_comb begin
      acc_vec = '0;
      if (state == OFFER && evt_ready) acc_vec[evt_idx] = 1'b1;
   end

   // A rise coinciding with its own accept is a fresh request, not an overrun
   assign pend_nxt = (pend & ~acc_vec) | rise | rpt;
   assign ovr_nxt  = (ovr & ~{N{ovr_clr}}) | (rise & pend & ~acc_vec);

   // Scan ptr, ptr+1, ... modulo N for the first pending request
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      scan      = '0;
      for (int unsigned k = 0; k < N; k++) begin
         scan = {1'b0, ptr} + SW'(k);
         if (scan >= SW'(N)) scan = scan - SW'(N);
         if (!sel_found && pend[scan[IDXW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = scan[IDXW-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trig_d <= '0;
         pend   <= '0;
         ovr    <= '0;
      end else begin
         trig_d <= in_trig;
         pend   <= pend_nxt;
         ovr    <= ovr_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         evt_valid <= 1'b0;
         evt_idx   <= '0;
         ptr       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_found) begin
                  evt_idx   <= sel_idx;
                  evt_valid <= 1'b1;
                  state     <= OFFER;
               end
            end
            OFFER: begin
               if (evt_ready) begin
                  evt_valid <= 1'b0;
                  ptr       <= (evt_idx == IDXW'(N - 1)) ? '0 : evt_idx + IDXW'(1);
                  state     <= IDLE;
               end
            end
            default: begin
               evt_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trig_event_arbiter.sv
// Self-checking bench for trig_event_arbiter: directed scenarios plus random traffic against a reference model.
module tb_trig_event_arbiter;

   localparam int unsigned N    = 4;
   localparam int unsigned IDXW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    in_trig;
   logic            evt_ready;
   logic            ovr_clr;
   logic            evt_valid;
   logic [IDXW-1:0] evt_idx;
   logic [N-1:0]    pend;
   logic [N-1:0]    ovr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   trig_event_arbiter #(.N(N), .IDXW(IDXW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_trig   (in_trig),
      .evt_ready (evt_ready),
      .ovr_clr   (ovr_clr),
      .evt_valid (evt_valid),
      .evt_idx   (evt_idx),
      .pend      (pend),
      .ovr       (ovr)
   );

   // Reference model: pending set, overrun set, offered request and fairness pointer
   logic [N-1:0] m_pend, m_ovr, m_td;
   bit           m_valid;
   int           m_idx, m_ptr;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pend = '0; m_ovr = '0; m_td = '0;
         m_valid = 0; m_idx = 0; m_ptr = 0;
      end else begin
         logic [N-1:0] np, no;
         bit r, acc;
         int j;
         for (int i = 0; i < N; i++) begin
            r     = in_trig[i] && !m_td[i];
            acc   = m_valid && evt_ready && (m_idx == i);
            np[i] = r || (m_pend[i] && !acc);
            no[i] = (r && m_pend[i] && !acc) || (m_ovr[i] && !ovr_clr);
         end
         m_td = in_trig;
         if (!m_valid) begin
            for (int k = 0; k < N; k++) begin
               j = (m_ptr + k) % N;
               if (!m_valid && m_pend[j]) begin
                  m_valid = 1;
                  m_idx   = j;
               end
            end
         end else if (evt_ready) begin
            m_valid = 0;
            m_ptr   = (m_idx + 1) % N;
         end
         m_pend = np;
         m_ovr  = no;
      end
   end

   task automatic tick(input logic [N-1:0] t, input logic r, input logic c);
      in_trig   = t;
      evt_ready = r;
      ovr_clr   = c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_trig = '0; evt_ready = 1'b0; ovr_clr = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
      checks++; if (evt_idx !== '0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", evt_idx); end
      checks++; if (pend !== '0) begin failures++; $display("FAIL reset_pend got=%b exp=0000", pend); end
      checks++; if (ovr !== '0) begin failures++; $display("FAIL reset_ovr got=%b exp=0000", ovr); end
   endtask

   task automatic test_single();
      int nvalid = 0;
      do_reset();
      tick(4'b0100, 1'b1, 1'b0);
      checks++; if (pend !== 4'b0100 || evt_valid !== 1'b0) begin
         failures++; $display("FAIL single_pend got pend=%b valid=%b exp pend=0100 valid=0", pend, evt_valid); end
      tick(4'b0100, 1'b1, 1'b0);
      checks++; if (evt_valid !== 1'b1 || evt_idx !== 2'd2) begin
         failures++; $display("FAIL single_offer got valid=%b idx=%0d exp valid=1 idx=2", evt_valid, evt_idx); end
      nvalid = 1;
      for (int c = 0; c < 12; c++) begin
         tick((c < 8) ? 4'b0100 : 4'b0000, 1'b1, 1'b0);
         if (evt_valid) nvalid++;
      end
      checks++; if (nvalid != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", nvalid); end
      checks++; if (pend !== '0) begin failures++; $display("FAIL single_pend_end got=%b exp=0000", pend); end
   endtask

   task automatic test_simultaneous();
      int seq[$];
      bit prev = 0, gap_ok = 1;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         tick(4'b1011, 1'b1, 1'b0);
         if (evt_valid) begin
            if (prev) gap_ok = 0;
            seq.push_back(int'(evt_idx));
         end
         prev = evt_valid;
      end
      checks++; if (seq.size() != 3 || seq[0] != 0 || seq[1] != 1 || seq[2] != 3) begin
         failures++; $display("FAIL simul_order got=%p exp='{0,1,3}", seq); end
      checks++; if (!gap_ok) begin failures++; $display("FAIL simul_gap got back-to-back valid exp idle cycle"); end
      // pointer wrapped to 0, so input 0 wins over input 3
      tick(4'b0000, 1'b1, 1'b0);
      tick(4'b1001, 1'b1, 1'b0);
      tick(4'b1001, 1'b1, 1'b0);
      checks++; if (evt_valid !== 1'b1 || evt_idx !== 2'd0) begin
         failures++; $display("FAIL simul_wrap got valid=%b idx=%0d exp valid=1 idx=0", evt_valid, evt_idx); end
      repeat (4) tick(4'b0000, 1'b1, 1'b0);
   endtask

   task automatic test_round_robin();
      int seq[$];
      do_reset();
      tick(4'b0010, 1'b1, 1'b0);
      repeat (3) tick(4'b0000, 1'b1, 1'b0);
      for (int c = 0; c < 8; c++) begin
         tick(4'b0101, 1'b1, 1'b0);
         if (evt_valid) seq.push_back(int'(evt_idx));
      end
      checks++; if (seq.size() != 2 || seq[0] != 2 || seq[1] != 0) begin
         failures++; $display("FAIL rr_order got=%p exp='{2,0}", seq); end
   endtask

   task automatic test_backpressure();
      int nacc = 0;
      do_reset();
      tick(4'b0010, 1'b0, 1'b0);
      tick(4'b0000, 1'b0, 1'b0);
      tick(4'b0010, 1'b0, 1'b0);
      tick(4'b0000, 1'b0, 1'b0);
      checks++; if (evt_valid !== 1'b1 || evt_idx !== 2'd1) begin
         failures++; $display("FAIL bp_hold got valid=%b idx=%0d exp valid=1 idx=1", evt_valid, evt_idx); end
      checks++; if (ovr !== 4'b0010 || pend !== 4'b0010) begin
         failures++; $display("FAIL bp_ovr got ovr=%b pend=%b exp ovr=0010 pend=0010", ovr, pend); end
      for (int c = 0; c < 6; c++) begin
         if (evt_valid) nacc++;
         tick(4'b0000, 1'b1, 1'b0);
      end
      checks++; if (nacc != 1 || pend !== '0) begin
         failures++; $display("FAIL bp_accept got accepts=%0d pend=%b exp accepts=1 pend=0000", nacc, pend); end
      checks++; if (ovr !== 4'b0010) begin failures++; $display("FAIL bp_sticky got=%b exp=0010", ovr); end
      tick(4'b0000, 1'b1, 1'b1);
      checks++; if (ovr !== '0) begin failures++; $display("FAIL bp_clr got=%b exp=0000", ovr); end
      tick(4'b0000, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid();
      int seq[$];
      do_reset();
      tick(4'b0110, 1'b0, 1'b0);
      tick(4'b0000, 1'b0, 1'b0);
      tick(4'b0000, 1'b0, 1'b0);
      checks++; if (evt_valid !== 1'b1 || pend !== 4'b0110) begin
         failures++; $display("FAIL mid_pre got valid=%b pend=%b exp valid=1 pend=0110", evt_valid, pend); end
      #1 rst = 1'b1;
      in_trig = 4'b1000;
      #1;
      checks++; if (evt_valid !== 1'b0 || evt_idx !== '0 || pend !== '0 || ovr !== '0) begin
         failures++; $display("FAIL mid_async got valid=%b idx=%0d pend=%b ovr=%b exp all zero", evt_valid, evt_idx, pend, ovr); end
      @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick(4'b1000, 1'b1, 1'b0);
         if (evt_valid) seq.push_back(int'(evt_idx));
      end
      checks++; if (seq.size() != 1 || seq[0] != 3) begin
         failures++; $display("FAIL mid_after got=%p exp='{3}", seq); end
      tick(4'b0000, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         tick(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
         checks++;
         if (evt_valid !== m_valid || evt_idx !== IDXW'(m_idx) || pend !== m_pend || ovr !== m_ovr) begin
            failures++;
            if (bad < 10) $display("FAIL random_c%0d got valid=%b idx=%0d pend=%b ovr=%b exp valid=%b idx=%0d pend=%b ovr=%b",
                                   c, evt_valid, evt_idx, pend, ovr, m_valid, m_idx, m_pend, m_ovr);
            bad++;
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_trig = '0; evt_ready = 1'b0; ovr_clr = 1'b0;
      test_reset();
      test_single();
      test_simultaneous();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
